// File: rtl/urcpu_pkg.sv
// Shared constants and FSM state encoding for the urcpu write-back path.
package urcpu_pkg;

  localparam int URCPU_DATA_W = 20;
  localparam int URCPU_ADDR_W = 4;

  // Plain 2-bit type with constant states, so older code that compares raw bits keeps working.
  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t WR_A = 2'd1;
  localparam state_t WR_B = 2'd2;

endpackage

// File: rtl/swap_writeback.sv
// Serialises a swapped data pair into two register-file writes (A then B) and pulses done.
// Optional SWAP_WB_SAME_ADDR_SKIP_EN: when both destinations match, only the B write is issued.
module swap_writeback
  import urcpu_pkg::*;
#(
  parameter int DATA_W = URCPU_DATA_W,
  parameter int ADDR_W = URCPU_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] output_a,
  input  logic [DATA_W-1:0] output_b,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic              wr_stall,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              done
);

  state_t            state_reg, state_next;
  logic [DATA_W-1:0] a_reg, b_reg;
  logic [ADDR_W-1:0] addr_a_reg, addr_b_reg;
  logic              wr_en_reg, wr_en_next;
  logic [ADDR_W-1:0] wr_addr_reg, wr_addr_next;
  logic [DATA_W-1:0] wr_data_reg, wr_data_next;
  logic              done_reg, done_next;
  logic              accept;
  logic              same_addr;
  logic [DATA_W-1:0] src_a, src_b;
  logic [ADDR_W-1:0] src_addr_a, src_addr_b;

  // A new pair can enter while the B write is committing, giving one pair per two cycles.
  assign in_ready = (state_reg == IDLE) || ((state_reg == WR_B) && !wr_stall);
  assign accept   = in_valid && in_ready;

`ifdef SWAP_WB_SAME_ADDR_SKIP_EN
  assign same_addr = (addr_a == addr_b);
`else
  assign same_addr = 1'b0;
`endif

  // On an accept the outputs are loaded straight from the inputs, since the capture
  // registers only update on that same edge.
  assign src_a      = accept ? output_a : a_reg;
  assign src_b      = accept ? output_b : b_reg;
  assign src_addr_a = accept ? addr_a   : addr_a_reg;
  assign src_addr_b = accept ? addr_b   : addr_b_reg;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (accept) state_next = same_addr ? WR_B : WR_A;
      end
      WR_A: begin
        if (!wr_stall) state_next = WR_B;
      end
      WR_B: begin
        if (!wr_stall) begin
          if (accept) state_next = same_addr ? WR_B : WR_A;
          else        state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    wr_en_next   = (state_next != IDLE);
    wr_addr_next = wr_addr_reg;
    wr_data_next = wr_data_reg;
    if (state_next == WR_A) begin
      wr_addr_next = src_addr_a;
      wr_data_next = src_a;
    end else if (state_next == WR_B) begin
      wr_addr_next = src_addr_b;
      wr_data_next = src_b;
    end
    done_next = (state_reg == WR_B) && !wr_stall;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      a_reg       <= '0;
      b_reg       <= '0;
      addr_a_reg  <= '0;
      addr_b_reg  <= '0;
      wr_en_reg   <= 1'b0;
      wr_addr_reg <= '0;
      wr_data_reg <= '0;
      done_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      wr_en_reg   <= wr_en_next;
      wr_addr_reg <= wr_addr_next;
      wr_data_reg <= wr_data_next;
      done_reg    <= done_next;
      if (accept) begin
        a_reg      <= output_a;
        b_reg      <= output_b;
        addr_a_reg <= addr_a;
        addr_b_reg <= addr_b;
      end
    end
  end

  assign wr_en   = wr_en_reg;
  assign wr_addr = wr_addr_reg;
  assign wr_data = wr_data_reg;
  assign done    = done_reg;

endmodule

// File: tb/tb_swap_writeback.sv
// Self-checking bench for swap_writeback: directed cycle checks plus a randomized soak
// scored against a register-file model.
module tb_swap_writeback;

  localparam int DW = 20;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] output_a, output_b;
  logic [AW-1:0] addr_a, addr_b;
  logic          wr_stall;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          done;

  swap_writeback dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .output_a (output_a),
    .output_b (output_b),
    .addr_a   (addr_a),
    .addr_b   (addr_b),
    .wr_stall (wr_stall),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .done     (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Register-file image built from committed writes (strobe high, no stall).
  logic [DW-1:0] obs_rf [16];
  int            wr_cnt   = 0;
  int            done_cnt = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (wr_en && !wr_stall) begin
        obs_rf[wr_addr] = wr_data;
        wr_cnt++;
      end
      if (done) done_cnt++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b,
                      input logic [AW-1:0] aa, input logic [AW-1:0] ab);
    in_valid = 1'b1;
    output_a = a;
    output_b = b;
    addr_a   = aa;
    addr_b   = ab;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [DW-1:0] exp_rf [16];
  logic [DW-1:0] in_a, in_b;
  logic [AW-1:0] sa, sb;
  logic          acc;
  logic          drained;
  int            w0, d0, exp_wr;

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    output_a = '0;
    output_b = '0;
    addr_a   = '0;
    addr_b   = '0;
    wr_stall = 1'b0;
    for (int i = 0; i < 16; i++) obs_rf[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_done", done, 0);
    rst_n = 1'b1;
    step();

    // Basic pair, no stalls.
    send(20'h12345, 20'hABCDE, 4'd3, 4'd7);
    check("basic_a_en", wr_en, 1);
    check("basic_a_addr", wr_addr, 3);
    check("basic_a_data", wr_data, 20'h12345);
    check("basic_a_ready", in_ready, 0);
    check("basic_a_done", done, 0);
    step();
    check("basic_b_en", wr_en, 1);
    check("basic_b_addr", wr_addr, 7);
    check("basic_b_data", wr_data, 20'hABCDE);
    check("basic_b_done", done, 0);
    step();
    check("basic_done", done, 1);
    check("basic_idle_en", wr_en, 0);
    step();
    check("basic_done_pulse", done, 0);

    // Two-cycle stall during the B write.
    send(20'h12345, 20'hABCDE, 4'd3, 4'd7);
    check("stall_a_addr", wr_addr, 3);
    step();
    wr_stall = 1'b1;
    #1;
    check("stall_b0_ready", in_ready, 0);
    check("stall_b0_addr", wr_addr, 7);
    check("stall_b0_data", wr_data, 20'hABCDE);
    step();
    check("stall_b1_en", wr_en, 1);
    check("stall_b1_addr", wr_addr, 7);
    check("stall_b1_done", done, 0);
    check("stall_b1_ready", in_ready, 0);
    step();
    check("stall_b2_addr", wr_addr, 7);
    check("stall_b2_data", wr_data, 20'hABCDE);
    check("stall_b2_done", done, 0);
    wr_stall = 1'b0;
    step();
    check("stall_done", done, 1);
    check("stall_idle_en", wr_en, 0);
    step();

    // Back-to-back pairs with in_valid held.
    in_valid = 1'b1;
    output_a = 20'h11111; output_b = 20'h22222; addr_a = 4'd4; addr_b = 4'd5;
    step();
    check("b2b_w4_addr", wr_addr, 4);
    check("b2b_w4_data", wr_data, 20'h11111);
    output_a = 20'h33333; output_b = 20'h44444; addr_a = 4'd6; addr_b = 4'd7;
    step();
    check("b2b_w5_addr", wr_addr, 5);
    check("b2b_w5_data", wr_data, 20'h22222);
    check("b2b_w5_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    check("b2b_w6_addr", wr_addr, 6);
    check("b2b_w6_data", wr_data, 20'h33333);
    check("b2b_w6_en", wr_en, 1);
    check("b2b_done1", done, 1);
    step();
    check("b2b_w7_addr", wr_addr, 7);
    check("b2b_w7_data", wr_data, 20'h44444);
    check("b2b_w7_done", done, 0);
    step();
    check("b2b_done2", done, 1);
    check("b2b_idle_en", wr_en, 0);
    step();

    // Same destination for both words.
    send(20'h00001, 20'hFFFFF, 4'd9, 4'd9);
`ifdef SWAP_WB_SAME_ADDR_SKIP_EN
    check("same_only_en", wr_en, 1);
    check("same_only_addr", wr_addr, 9);
    check("same_only_data", wr_data, 20'hFFFFF);
    step();
    check("same_done", done, 1);
    check("same_idle_en", wr_en, 0);
`else
    check("same_a_addr", wr_addr, 9);
    check("same_a_data", wr_data, 20'h00001);
    step();
    check("same_b_addr", wr_addr, 9);
    check("same_b_data", wr_data, 20'hFFFFF);
    check("same_b_done", done, 0);
    step();
    check("same_done", done, 1);
    check("same_idle_en", wr_en, 0);
`endif
    step();
    check("same_rf9", obs_rf[9], 20'hFFFFF);

    // Reset while the A write is on the bus drops the pair.
    send(20'h55555, 20'h66666, 4'd2, 4'd8);
    check("rstmid_en_before", wr_en, 1);
    rst_n = 1'b0;
    #1;
    check("rstmid_en", wr_en, 0);
    check("rstmid_ready", in_ready, 1);
    check("rstmid_done", done, 0);
    step();
    check("rstmid_en_held", wr_en, 0);
    w0 = wr_cnt;
    d0 = done_cnt;
    rst_n = 1'b1;
    repeat (4) step();
    check("rstmid_no_write", wr_cnt - w0, 0);
    check("rstmid_no_done", done_cnt - d0, 0);
    check("rstmid_en_after", wr_en, 0);

    // Randomized soak: model applies each swapped pair as A-then-B writes.
    void'($urandom(18424));
    for (int i = 0; i < 16; i++) exp_rf[i] = obs_rf[i];
    w0     = wr_cnt;
    d0     = done_cnt;
    exp_wr = 0;
    for (int it = 0; it < 10; it++) begin
      in_a = DW'($urandom);
      in_b = DW'($urandom);
      sa   = AW'($urandom_range(0, 15));
      sb   = ($urandom_range(0, 3) == 0) ? sa : AW'($urandom_range(0, 15));
      // The swap stage crosses the words over.
      in_valid = 1'b1;
      output_a = in_b;
      output_b = in_a;
      addr_a   = sa;
      addr_b   = sb;
      acc      = 1'b0;
      for (int c = 0; c < 64 && !acc; c++) begin
        wr_stall = ($urandom_range(0, 3) == 0);
        #1;
        acc = in_ready;
        step();
      end
      check("soak_accept", acc, 1);
      in_valid = 1'b0;
      exp_rf[sa] = in_b;
      exp_rf[sb] = in_a;
`ifdef SWAP_WB_SAME_ADDR_SKIP_EN
      exp_wr += (sa == sb) ? 1 : 2;
`else
      exp_wr += 2;
`endif
      $display("pair %0d: input_a=%05h input_b=%05h addr_a=%0d addr_b=%0d", it, in_a, in_b, sa, sb);
      repeat ($urandom_range(0, 2)) begin
        wr_stall = ($urandom_range(0, 3) == 0);
        step();
      end
    end
    wr_stall = 1'b0;
    drained  = 1'b0;
    for (int c = 0; c < 20 && !drained; c++) begin
      step();
      drained = !wr_en;
    end
    check("soak_drain", drained, 1);
    step();
    check("soak_done_count", done_cnt - d0, 10);
    check("soak_write_count", wr_cnt - w0, exp_wr);
    for (int i = 0; i < 16; i++) check($sformatf("soak_rf%0d", i), obs_rf[i], exp_rf[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/swap_writeback.md
Name: swap_writeback

Overview:
- Downstream stage of swap_module: captures its two 20-bit outputs plus two destination register addresses and writes them back through the register file's single write port.
- Serialises the pair into two write cycles, destination A then destination B, under a valid/ready handshake on the input side and a stall input on the register-file side.
- Signals completion of each swap with a one-cycle done pulse to the control unit.

Parameters:
- DATA_W, 20, width of each data word (matches swap_module ports).
- ADDR_W, 4, register-file address width.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream has a swapped pair ready.
- in_ready  output  1  block can accept a pair this cycle.
- output_a  input  DATA_W  swapped word bound for addr_a (from swap_module output_a).
- output_b  input  DATA_W  swapped word bound for addr_b (from swap_module output_b).
- addr_a  input  ADDR_W  destination register for output_a.
- addr_b  input  ADDR_W  destination register for output_b.
- wr_stall  input  1  register file cannot take a write this cycle.
- wr_en  output  1  register-file write strobe.
- wr_addr  output  ADDR_W  write address.
- wr_data  output  DATA_W  write data.
- done  output  1  one-cycle pulse after the second write commits.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE, in_ready=1, wr_en=0, wr_addr=0, wr_data=0, done=0, capture registers=0. Reset mid-operation drops the pending pair; no partial write follows deassertion.
- Accept: transfer occurs on a rising edge with in_valid && in_ready. It latches output_a, output_b, addr_a and addr_b. Inputs are ignored at all other times.
- States:
  - IDLE: in_ready=1, wr_en=0. On accept -> WR_A.
  - WR_A: wr_en=1, wr_addr=latched addr_a, wr_data=latched a. If wr_stall, hold WR_A with outputs unchanged. Else -> WR_B.
  - WR_B: wr_en=1, wr_addr=latched addr_b, wr_data=latched b. If wr_stall, hold WR_B. Else the write commits, done=1 on the next cycle, and next state is IDLE.
- Back-to-back: in_ready is also 1 in WR_B when wr_stall=0. An accept there goes directly WR_B -> WR_A with the new pair, so sustained throughput is one pair per 2 cycles.
- Outputs are registered: wr_en/wr_addr/wr_data appear the cycle after accept. Latency from accept to first write is 1 cycle; to done is 3 cycles with no stalls.
- done is registered, 1 cycle wide, and asserts even when a new pair was accepted in the same cycle.
- wr_stall is ignored in IDLE.
- Same address (addr_a==addr_b): both writes are issued; B is last, so register holds output_b.
- No arithmetic; data passes through unmodified at full DATA_W.

Optional Feature:
- Macro SWAP_WB_SAME_ADDR_SKIP_EN.
- Defined: when latched addr_a==addr_b, the accept transitions straight to WR_B. WR_A never issues, and done comes 2 cycles after accept.
- Undefined: both writes always issue, as described in Behaviour.
- Final register contents are identical in both builds.

Decomposition:
- Shared package urcpu_pkg: DATA_W=20, ADDR_W=4 constants, and the state enum (IDLE, WR_A, WR_B) as a 2-bit typedef.
- No sub-module: a single FSM with capture registers is sufficient; swap_module stays a separate instance in the parent.

Test Plan:
- Reset: assert rst_n=0 mid-WR_A -> next cycle wr_en=0, in_ready=1, done=0. After release, no write of the dropped pair appears.
- Basic: accept a=20'h12345, b=20'hABCDE, addr_a=3, addr_b=7, no stall:
  - cycle+1: wr_en=1, addr 3, data 12345.
  - cycle+2: addr 7, data ABCDE.
  - cycle+3: done=1, wr_en=0.
- Stall: same pair with wr_stall=1 for 2 cycles during WR_B -> addr 7/ABCDE held for 3 cycles, done delayed 2 cycles, in_ready=0 while stalled.
- Back-to-back: in_valid held with pairs (1,2)->(4,5) then (3,4)->(6,7) -> writes to 4, 5, 6, 7 on consecutive cycles, done pulses after the 5 and 7 writes.
- Same address: addr_a=addr_b=9, a=20'h00001, b=20'hFFFFF:
  - macro off: two writes, last data FFFFF.
  - macro on: single write FFFFF, done at cycle+2.
- Random soak: 10 iterations with $urandom seed 18424 driving through swap_module into this block -> scoreboard register model matches: reg[addr_a]=original input_b, reg[addr_b]=original input_a.
